// File: rtl/ps_window_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps_window_ctrl_if
//   Bundles the pixel input, the downstream read permit, the four line-buffer
//   read/write lanes and the kernel output of ps_window_ctrl.
//
//   master : environment side. Drives pixels, the read permit and line-buffer
//            read data. Receives the write/read enables and the kernel.
//   slave  : ps_window_ctrl side.
//
//   Signals (names seen from the controller):
//     i_valid, i_data         input pixel strobe and pixel
//     i_rd_en                 downstream permits starting a new line read
//     i_lb_rdata0..3          line-buffer outputs {left, center, right}
//     o_lb_wr, o_lb_wdata     one-hot line-buffer write enable, write data
//     o_lb_rd                 line-buffer read enables (three bits during READ)
//     o_kernel                {top, middle, bottom} rows, each {left, center, right}
//     o_valid, o_border       kernel valid, kernel at first or last column
//     o_overflow              sticky flag: a pixel was dropped
// ----------------------------------------------------------------------------
interface ps_window_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      i_valid;
    logic [DATA_WIDTH-1:0]     i_data;
    logic                      i_rd_en;
    logic [3*DATA_WIDTH-1:0]   i_lb_rdata0;
    logic [3*DATA_WIDTH-1:0]   i_lb_rdata1;
    logic [3*DATA_WIDTH-1:0]   i_lb_rdata2;
    logic [3*DATA_WIDTH-1:0]   i_lb_rdata3;
    logic [3:0]                o_lb_wr;
    logic [DATA_WIDTH-1:0]     o_lb_wdata;
    logic [3:0]                o_lb_rd;
    logic [9*DATA_WIDTH-1:0]   o_kernel;
    logic                      o_valid;
    logic                      o_border;
    logic                      o_overflow;

    modport master (
        output i_valid, i_data, i_rd_en,
        output i_lb_rdata0, i_lb_rdata1, i_lb_rdata2, i_lb_rdata3,
        input  o_lb_wr, o_lb_wdata, o_lb_rd,
        input  o_kernel, o_valid, o_border, o_overflow
    );

    modport slave (
        input  i_valid, i_data, i_rd_en,
        input  i_lb_rdata0, i_lb_rdata1, i_lb_rdata2, i_lb_rdata3,
        output o_lb_wr, o_lb_wdata, o_lb_rd,
        output o_kernel, o_valid, o_border, o_overflow
    );
endinterface

// File: rtl/ps_window_ctrl.sv
// ----------------------------------------------------------------------------
// ps_window_ctrl
//   Sequences four line buffers into a 3x3 sliding window. Pixels are written
//   into the buffers in rotation; once three complete lines are held and
//   downstream permits, the three oldest lines are read in lockstep and a
//   registered 72-bit kernel is assembled (top row = oldest line).
//
//   Ports:
//     i_clk   single clock
//     i_rstn  synchronous active-low reset, shared with the line buffers
//     bus     ps_window_ctrl_if.slave (pixel in, line-buffer lanes, kernel out)
// ----------------------------------------------------------------------------
module ps_window_ctrl #(
    parameter int LINE_LENGTH = 640,
    parameter int DATA_WIDTH  = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    ps_window_ctrl_if.slave  bus
);
    localparam int              CNT_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_LENGTH - 1);
    localparam int              ROW_W = 3 * DATA_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    // Write side
    logic [1:0]       wr_sel_q, wr_sel_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [2:0]       fill_q, fill_d;
    logic             overflow_q, overflow_d;
    logic             drop, accept, line_done;
    logic [3:0]       lb_wr;

    // Read side
    state_t           state_q, state_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             retire;
    logic [3:0]       lb_rd;

    // Pipeline aligned with the one-cycle line-buffer read latency
    logic [1:0]       rd_sel_p_q;
    logic [CNT_W-1:0] rd_cnt_p_q;
    logic             read_p_q;
    logic             valid_q, border_q;
    logic [9*DATA_WIDTH-1:0] kernel_q, kernel_d;
    logic [ROW_W-1:0] rdata [4];

    // ------------------------------------------------------------------------
    // Write side: rotate through the buffers one whole line at a time.
    // Writes are also gated by reset so no buffer is written while the block
    // and the buffers are being cleared.
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        drop       = (fill_q == 3'd4);
        accept     = i_rstn && bus.i_valid && !drop;
        line_done  = accept && (wr_cnt_q == LAST);
        wr_sel_d   = wr_sel_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q | (bus.i_valid && drop);
        lb_wr      = 4'b0000;
        if (accept) begin
            lb_wr = 4'b0001 << wr_sel_q;
            if (line_done) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM: one line per READ visit, always followed by one IDLE cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rd_sel_d = rd_sel_q;
        rd_cnt_d = rd_cnt_q;
        retire   = 1'b0;
        lb_rd    = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                if (fill_q >= 3'd3 && bus.i_rd_en) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Three consecutive buffers starting at rd_sel are read; the
                // only one left out is rd_sel+3, the buffer being written.
                lb_rd = ~(4'b0001 << (rd_sel_q + 2'd3));
                if (rd_cnt_q == LAST) begin
                    retire   = 1'b1;
                    rd_cnt_d = '0;
                    rd_sel_d = rd_sel_q + 2'd1;
                    state_d  = S_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completed-but-unretired lines; simultaneous complete and retire cancel.
    always_comb begin
        fill_d = fill_q;
        case ({line_done, retire})
            2'b10:   fill_d = fill_q + 3'd1;
            2'b01:   fill_d = fill_q - 3'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Kernel rows in age order: the buffer at the delayed rd_sel is the oldest.
    always_comb begin
        rdata[0] = bus.i_lb_rdata0;
        rdata[1] = bus.i_lb_rdata1;
        rdata[2] = bus.i_lb_rdata2;
        rdata[3] = bus.i_lb_rdata3;
        kernel_d = {rdata[rd_sel_p_q],
                    rdata[rd_sel_p_q + 2'd1],
                    rdata[rd_sel_p_q + 2'd2]};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_sel_q   <= '0;
            wr_cnt_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            rd_sel_q   <= '0;
            rd_cnt_q   <= '0;
            rd_sel_p_q <= '0;
            rd_cnt_p_q <= '0;
            read_p_q   <= 1'b0;
            valid_q    <= 1'b0;
            border_q   <= 1'b0;
            kernel_q   <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            wr_cnt_q   <= wr_cnt_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            rd_sel_q   <= rd_sel_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_sel_p_q <= rd_sel_q;
            rd_cnt_p_q <= rd_cnt_q;
            read_p_q   <= (state_q == S_READ);
            valid_q    <= read_p_q;
            // rd_cnt rests at 0 while idle, so border is qualified by the read.
            border_q   <= read_p_q && ((rd_cnt_p_q == '0) || (rd_cnt_p_q == LAST));
            if (read_p_q) begin
                kernel_q <= kernel_d;
            end
        end
    end

    assign bus.o_lb_wr    = lb_wr;
    assign bus.o_lb_wdata = bus.i_data;
    assign bus.o_lb_rd    = lb_rd;
    assign bus.o_kernel   = kernel_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_border   = border_q;
    assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_ps_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps_window_ctrl
//   Directed bench for ps_window_ctrl with LINE_LENGTH=8. Four behavioural
//   line buffers (one-cycle read latency, zero beyond the line ends) sit
//   behind the controller. Expected kernels are queued when the line that
//   completes a window is streamed and popped whenever o_valid is seen.
// ----------------------------------------------------------------------------
module tb_ps_window_ctrl;
    localparam int LL = 8;
    localparam int DW = 8;
    localparam int KW = 9 * DW;

    typedef struct packed {
        logic [KW-1:0] kernel;
        logic          border;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ps_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    ps_window_ctrl #(.LINE_LENGTH(LL), .DATA_WIDTH(DW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];
    exp_t mon_e;
    int   exp_wr_sel = 0;

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural line buffers ----------------
    logic [DW-1:0]   lb_mem [4][LL];
    int              lb_wp [4];
    int              lb_rp [4];
    logic [3*DW-1:0] lb_out [4];

    function automatic logic [3*DW-1:0] lb_word(input int b, input int p);
        logic [DW-1:0] l, c, r;
        l = (p == 0)      ? '0 : lb_mem[b][p-1];
        c = lb_mem[b][p];
        r = (p == LL - 1) ? '0 : lb_mem[b][p+1];
        return {l, c, r};
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            for (int b = 0; b < 4; b++) begin
                lb_wp[b]  <= 0;
                lb_rp[b]  <= 0;
                lb_out[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_lb_wr[b]) begin
                    lb_mem[b][lb_wp[b]] <= bus.o_lb_wdata;
                    lb_wp[b]            <= (lb_wp[b] + 1) % LL;
                end
                if (bus.o_lb_rd[b]) begin
                    lb_out[b] <= lb_word(b, lb_rp[b]);
                    lb_rp[b]  <= (lb_rp[b] + 1) % LL;
                end
            end
        end
    end

    assign bus.i_lb_rdata0 = lb_out[0];
    assign bus.i_lb_rdata1 = lb_out[1];
    assign bus.i_lb_rdata2 = lb_out[2];
    assign bus.i_lb_rdata3 = lb_out[3];

    // ---------------- expected values ----------------
    function automatic logic [DW-1:0] pix(input int row, input int col);
        return DW'(row * 16 + col);
    endfunction

    function automatic logic [3*DW-1:0] lcr(input int row, input int col);
        logic [DW-1:0] l, r;
        l = (col == 0)      ? '0 : pix(row, col - 1);
        r = (col == LL - 1) ? '0 : pix(row, col + 1);
        return {l, pix(row, col), r};
    endfunction

    task automatic push_read(input int top);
        exp_t e;
        for (int c = 0; c < LL; c++) begin
            e.kernel = {lcr(top, c), lcr(top + 1, c), lcr(top + 2, c)};
            e.border = (c == 0) || (c == LL - 1);
            sb.push_back(e);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rstn && bus.o_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty: observed o_valid=1 expected no kernel");
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("kernel", bus.o_kernel, mon_e.kernel);
                check("border", KW'(bus.o_border), KW'(mon_e.border));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_line(input int row);
        for (int c = 0; c < LL; c++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = pix(row, c);
            #1;
            check("lb_wr", KW'(bus.o_lb_wr), KW'(4'b0001 << exp_wr_sel));
            tick();
        end
        bus.i_valid = 1'b0;
        exp_wr_sel  = (exp_wr_sel + 1) % 4;
    endtask

    // Entered one cycle after the line's last accepted pixel (cycle t+1).
    task automatic read_after_line(input logic [3:0] exp_rd);
        int k;
        int n;
        k = 1;
        @(negedge clk);
        while (bus.o_lb_rd == 4'b0000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rd_start_lat", KW'(k), KW'(2));
        check("lb_rd", KW'(bus.o_lb_rd), KW'(exp_rd));
        while (!bus.o_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("valid_lat", KW'(k), KW'(4));
        n = 0;
        while (bus.o_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("valid_len", KW'(n), KW'(LL));
        tick();
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("drain", KW'(sb.size()), KW'(0));
        tick();
        tick();
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        tick();
        tick();
        sb.delete();
        rstn       = 1'b1;
        exp_wr_sel = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] rot_pat [4];
        rot_pat[0] = 4'b0111;
        rot_pat[1] = 4'b1110;
        rot_pat[2] = 4'b1101;
        rot_pat[3] = 4'b1011;

        // Reset with random inputs
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'($urandom_range(0, 1));
            bus.i_data  = DW'($urandom);
            bus.i_rd_en = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_lb_wr",    KW'(bus.o_lb_wr),    '0);
        check("rst_lb_rd",    KW'(bus.o_lb_rd),    '0);
        check("rst_kernel",   bus.o_kernel,        '0);
        check("rst_valid",    KW'(bus.o_valid),    '0);
        check("rst_border",   KW'(bus.o_border),   '0);
        check("rst_overflow", KW'(bus.o_overflow), '0);
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_rd_en = 1'b0;
        rstn        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_lb_rd",  KW'(bus.o_lb_rd),  '0);
            check("idle_valid",  KW'(bus.o_valid),  '0);
            check("idle_border", KW'(bus.o_border), '0);
            check("idle_ovf",    KW'(bus.o_overflow), '0);
        end

        // First kernel, then rotation through all four read positions
        bus.i_rd_en = 1'b1;
        stream_line(0);
        stream_line(1);
        push_read(0);
        stream_line(2);
        read_after_line(rot_pat[0]);
        for (int r = 3; r < 6; r++) begin
            push_read(r - 2);
            stream_line(r);
            read_after_line(rot_pat[r - 2]);
        end

        // Line-complete coincides with read-retire
        push_read(4);
        stream_line(6);
        tick();
        push_read(5);
        stream_line(7);
        check("idle_gap", KW'(bus.o_lb_rd), KW'(4'b0000));
        tick();
        check("back_to_back", KW'(bus.o_lb_rd), KW'(4'b1110));
        wait_drain();

        // Overflow with reads held off
        do_reset();
        bus.i_rd_en = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (r >= 2) push_read(r - 2);
            stream_line(r);
        end
        check("held_no_read", KW'(bus.o_lb_rd), '0);
        check("pre_drop_ovf", KW'(bus.o_overflow), '0);
        bus.i_valid = 1'b1;
        bus.i_data  = pix(4, 0);
        #1;
        check("drop_lb_wr", KW'(bus.o_lb_wr), '0);
        tick();
        bus.i_valid = 1'b0;
        check("overflow_set", KW'(bus.o_overflow), KW'(1));
        bus.i_rd_en = 1'b1;
        wait_drain();
        check("overflow_sticky", KW'(bus.o_overflow), KW'(1));

        // Reset in the 4th READ cycle, then a fresh first kernel
        do_reset();
        check("overflow_cleared", KW'(bus.o_overflow), '0);
        stream_line(0);
        stream_line(1);
        push_read(0);
        stream_line(2);
        for (int i = 0; i < 4; i++) tick();
        check("in_read", KW'(bus.o_lb_rd), KW'(4'b0111));
        rstn = 1'b0;
        tick();
        check("abort_valid",  KW'(bus.o_valid), '0);
        check("abort_lb_rd",  KW'(bus.o_lb_rd), '0);
        check("abort_kernel", bus.o_kernel,     '0);
        check("abort_border", KW'(bus.o_border), '0);
        tick();
        sb.delete();
        rstn       = 1'b1;
        exp_wr_sel = 0;
        stream_line(0);
        stream_line(1);
        push_read(0);
        stream_line(2);
        read_after_line(rot_pat[0]);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps_window_ctrl.md
# ps_window_ctrl

Sequencing controller for four `ps_linebuffer` instances that together form a 3×3 sliding pixel window. Incoming pixels are written into the four line buffers in rotation. Whenever three complete lines are held and downstream permits, the block reads those three lines in lockstep and assembles a registered 72-bit kernel for the convolution or filter stage.

## Interface
- `LINE_LENGTH`, 640: pixels per line; must match the line buffers.
- `DATA_WIDTH`, 8: bits per pixel.
- `i_clk` in 1: single clock.
- `i_rstn` in 1: reset, synchronous and active-low; it is shared with the line buffers.
- `i_valid` in 1: input pixel strobe.
- `i_data` in DATA_WIDTH: input pixel.
- `i_rd_en` in 1: downstream permits starting a new line read.
- `o_lb_wr` out 4: one-hot write enable to line buffers 0..3.
- `o_lb_wdata` out DATA_WIDTH: write data; combinational copy of `i_data`.
- `o_lb_rd` out 4: read enables; exactly three bits set during READ.
- `i_lb_rdata0`..`i_lb_rdata3` in 3*DATA_WIDTH each: line buffer outputs {left, center, right}.
- `o_kernel` out 9*DATA_WIDTH: {top, middle, bottom} rows, each {left, center, right}.
- `o_valid` out 1: `o_kernel` is valid this cycle.
- `o_border` out 1: the current kernel is at column 0 or column LINE_LENGTH-1.
- `o_overflow` out 1: sticky flag; a pixel was dropped.

## Operation
- **Write side:** 2-bit `wr_sel` and a pixel counter `wr_cnt`.
  - `o_lb_wr = i_valid && !drop ? onehot(wr_sel) : 0`.
  - On an accepted pixel with `wr_cnt == LINE_LENGTH-1`: `wr_cnt` goes to 0, `wr_sel` goes to `wr_sel+1` mod 4, and a line-complete event is raised.
- **Fill count `fill`:** range 0..4; counts complete lines not yet retired.
  - Increments on line-complete.
  - Decrements on read-retire.
  - When both occur in the same cycle, `fill` is unchanged.
- **Drop rule:** `drop = (fill == 4)`.
  - A dropped pixel causes no write and no `wr_cnt` change.
  - `o_overflow` is set to 1 and holds until reset.
- **Read FSM:** two states, IDLE and READ.
  - IDLE → READ when `fill >= 3 && i_rd_en`. The transition evaluates registered `fill`.
  - In READ, `o_lb_rd` has bits `rd_sel`, `rd_sel+1`, `rd_sel+2` (mod 4) set, decoded from the state. `rd_cnt` increments every cycle.
  - At `rd_cnt == LINE_LENGTH-1`: read-retire is raised, `rd_sel` goes to `rd_sel+1` mod 4, `rd_cnt` goes to 0, and the FSM returns to IDLE.
  - IDLE always lasts at least 1 cycle, so the read throughput is LINE_LENGTH+1 cycles per line.
  - `i_rd_en` is sampled only in IDLE. A line read, once started, always completes.
- **Kernel assembly:** `rd_sel`, `rd_cnt` and READ are delayed 1 cycle to align with line-buffer output latency.
  - `o_kernel` is registered as {rdata[sel], rdata[sel+1], rdata[sel+2]}, using the delayed `sel`. Top is the oldest line.
  - `o_valid` is the 2-cycle-delayed READ.
  - `o_border` is 1 when the 2-cycle-delayed `rd_cnt` is 0 or LINE_LENGTH-1.
  - Border pixel contents are not masked; downstream handles edges.
- **Pointer alignment:** line-buffer read and write pointers stay aligned because whole lines are always written and read.

## Timing
- **Reset values:** `o_lb_wr=0`, `o_lb_rd=0`, `o_kernel=0`, `o_valid=0`, `o_border=0`, `o_overflow=0`. Internally `wr_sel=rd_sel=0`, `wr_cnt=rd_cnt=0`, `fill=0`, state IDLE.
- **Mid-operation reset:** reset during READ aborts the line and returns everything to the reset values in the next cycle. Line buffers reset together with the block.
- **Write latency:** `o_lb_wr` is combinational, in the same cycle as `i_valid`.
- **Read start:** if the third line's last pixel is accepted at cycle t and `i_rd_en=1`, `fill=3` at t+1, READ and `o_lb_rd` are active at t+2, and the first `o_valid` is at t+4.
- **Read duration:** `o_valid` is high for exactly LINE_LENGTH consecutive cycles per line.
- **Wrap:** `wr_sel` and `rd_sel` wrap 3 → 0.

## Test plan
- **Reset:** assert `i_rstn=0` for 2 cycles with random inputs → all outputs are 0 and `o_lb_rd=0` for 10 cycles after release with no input.
- **First kernel:** use LINE_LENGTH=8, `i_rd_en=1`, and stream 3 lines with pixel = row*16+col.
  - Expect `o_lb_wr` to step 0001 → 0010 → 0100.
  - `o_valid` rises 4 cycles after the last write and stays high for 8 cycles.
  - At the valid cycle for col 3, the center bytes are 0x03, 0x13, 0x23 (top to bottom) and `o_border=0`.
  - `o_border=1` on the first and last valid cycles.
- **Rotation:** stream 6 lines.
  - Reads occur in the order rd_sel 0, 1, 2, 3.
  - The fourth read sets `o_lb_rd=1011` and produces top/mid/bottom centers from rows 3, 4, 5.
  - `wr_sel` wraps back to 0 after line 3.
- **Simultaneous events:** time a line-complete to coincide with read-retire → `fill` is unchanged and the next read starts after exactly 1 IDLE cycle.
- **Overflow:** hold `i_rd_en=0` and write 4 lines → `fill=4`.
  - The next pixel is dropped, `o_lb_wr=0` and `o_overflow=1`.
  - Raising `i_rd_en` lets the read proceed; `o_overflow` stays 1 until reset.
- **Mid-read reset:** reset at the 4th READ cycle → `o_valid=0` from the next cycle; a fresh 3-line stream then reproduces the first-kernel results exactly.
